// File: rtl/core_pkg.sv
// Shared core constants and the writeback-queue entry payload.
package core_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned WBQ_DEPTH = 4;

  // One buffered result: valid flag, destination register and value.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wbq_entry_t;

endpackage

// File: rtl/wbq_match.sv
// Priority matcher: finds the youngest valid entry targeting q_rs.
module wbq_match
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = WBQ_DEPTH
) (
  input  wbq_entry_t                   entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]     head,
  input  logic [REG_AW-1:0]            q_rs,
  output logic                         q_hit,
  output logic [XLEN-1:0]              q_data
);

  localparam int unsigned IW = $clog2(DEPTH);

  logic [IW-1:0] idx;

  // Walk oldest to youngest from head; later matches overwrite earlier ones.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + IW'(i);
      if (q_rs != '0 && entries[idx].valid && entries[idx].rd == q_rs) begin
        q_hit  = 1'b1;
        q_data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// In-order writeback buffer for long-latency results, draining into the
// regfile write port when the main pipeline leaves it free.
// Optional: define WBQ_BYPASS_EN to forward a result straight to the port
// when the queue is empty and the port is free.
module wb_queue #(
  parameter int unsigned DEPTH  = core_pkg::WBQ_DEPTH,
  parameter int unsigned XLEN   = core_pkg::XLEN,
  parameter int unsigned REG_AW = core_pkg::REG_AW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [REG_AW-1:0]          in_rd,
  input  logic [XLEN-1:0]            in_data,
  input  logic                       port_busy,
  output logic                       wr_en,
  output logic [REG_AW-1:0]          wr_addr,
  output logic [XLEN-1:0]            wr_data,
  input  logic [REG_AW-1:0]          q_rs,
  output logic                       q_hit,
  output logic [XLEN-1:0]            q_data,
  output logic [$clog2(DEPTH):0]     count
);

  import core_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  wbq_entry_t      entries [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count_q;

  logic empty;
  logic full;
  logic bypass;
  logic push;
  logic pop;

  // Occupancy flags come from the counter so wrap-around needs no extra bit.
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign in_ready = !full;
  assign count    = count_q;

`ifdef WBQ_BYPASS_EN
  assign bypass = empty && !port_busy && in_valid && (in_rd != '0);
`else
  assign bypass = 1'b0;
`endif

  // x0 results complete the handshake but are never stored.
  assign push = in_valid && in_ready && (in_rd != '0) && !bypass;
  assign pop  = !empty && !port_busy;

  // Regfile port drive; held at zero while idle or in reset.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (rst) begin
      if (pop) begin
        wr_en   = 1'b1;
        wr_addr = entries[head].rd;
        wr_data = entries[head].data;
      end else if (bypass) begin
        wr_en   = 1'b1;
        wr_addr = in_rd;
        wr_data = in_data;
      end
    end
  end

  // Entry storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (push) begin
        entries[tail] <= '{valid: 1'b1, rd: in_rd, data: in_data};
        tail          <= tail + AW'(1);
      end
      if (pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Pending-destination lookup for hazard and forwarding logic.
  wbq_match #(
    .DEPTH(DEPTH)
  ) u_match (
    .entries (entries),
    .head    (head),
    .q_rs    (q_rs),
    .q_hit   (q_hit),
    .q_data  (q_data)
  );

endmodule

// File: tb/tb_wb_queue.sv
// Directed testbench for wb_queue: vector table plus multi-cycle sequences.
module tb_wb_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        port_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  q_rs;
  logic        q_hit;
  logic [31:0] q_data;
  logic [2:0]  count;

  int checks;
  int failures;

  typedef struct {
    logic        iv;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        busy;
    logic [4:0]  qrs;
    logic        e_rdy;
    logic        e_wen;
    logic [4:0]  e_addr;
    logic [31:0] e_wdata;
    logic        e_hit;
    logic [31:0] e_qdata;
    logic [2:0]  e_cnt;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  wb_queue dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rd     (in_rd),
    .in_data   (in_data),
    .port_busy (port_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .q_rs      (q_rs),
    .q_hit     (q_hit),
    .q_data    (q_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic iv, logic [4:0] rd, logic [31:0] data, logic busy,
                              logic [4:0] qrs, logic e_rdy, logic e_wen, logic [4:0] e_addr,
                              logic [31:0] e_wdata, logic e_hit, logic [31:0] e_qdata,
                              logic [2:0] e_cnt);
    vec_t v;
    v.iv = iv; v.rd = rd; v.data = data; v.busy = busy; v.qrs = qrs;
    v.e_rdy = e_rdy; v.e_wen = e_wen; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_hit = e_hit; v.e_qdata = e_qdata; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [4:0] rd, input logic [31:0] data,
                       input logic busy, input logic [4:0] qrs);
    in_valid  = iv;
    in_rd     = rd;
    in_data   = data;
    port_busy = busy;
    q_rs      = qrs;
  endtask

  task automatic expect_out(input string nm, input logic rdy, input logic wen,
                            input logic [4:0] addr, input logic [31:0] wd, input logic hit,
                            input logic [31:0] qd, input logic [2:0] cnt);
    check({nm, ".in_ready"}, 32'(in_ready), 32'(rdy));
    check({nm, ".wr_en"},    32'(wr_en),    32'(wen));
    check({nm, ".wr_addr"},  32'(wr_addr),  32'(addr));
    check({nm, ".wr_data"},  wr_data,       wd);
    check({nm, ".q_hit"},    32'(q_hit),    32'(hit));
    check({nm, ".q_data"},   q_data,        qd);
    check({nm, ".count"},    32'(count),    32'(cnt));
  endtask

  // Advance one cycle; inputs are driven #1 after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Test 1: single result, port free.
`ifdef WBQ_BYPASS_EN
    vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 5,  1, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0,            0, 5,  1, 0, 0, 0,            0, 0, 0);
`else
    vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 5,  1, 0, 0, 0,            0, 0,            0);
    vecs[1]  = mk(0, 0, 0,            0, 5,  1, 1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1);
`endif
    vecs[2]  = mk(0, 0, 0,          0, 5,  1, 0, 0, 0,          0, 0,          0);
    // Test 2: fill while port busy, blocked 5th push, in-order drain.
    vecs[3]  = mk(1, 1, 32'h101,    1, 3,  1, 0, 0, 0,          0, 0,          0);
    vecs[4]  = mk(1, 2, 32'h102,    1, 3,  1, 0, 0, 0,          0, 0,          1);
    vecs[5]  = mk(1, 3, 32'h103,    1, 3,  1, 0, 0, 0,          0, 0,          2);
    vecs[6]  = mk(1, 4, 32'h104,    1, 3,  1, 0, 0, 0,          1, 32'h103,    3);
    vecs[7]  = mk(1, 5, 32'h105,    1, 3,  0, 0, 0, 0,          1, 32'h103,    4);
    vecs[8]  = mk(1, 5, 32'h105,    0, 3,  0, 1, 1, 32'h101,    1, 32'h103,    4);
    vecs[9]  = mk(0, 0, 0,          0, 3,  1, 1, 2, 32'h102,    1, 32'h103,    3);
    vecs[10] = mk(0, 0, 0,          0, 3,  1, 1, 3, 32'h103,    1, 32'h103,    2);
    vecs[11] = mk(0, 0, 0,          0, 3,  1, 1, 4, 32'h104,    0, 0,          1);
    vecs[12] = mk(0, 0, 0,          0, 3,  1, 0, 0, 0,          0, 0,          0);
    // Test 3: duplicate destination, youngest wins; x0 and absent reg miss.
    vecs[13] = mk(1, 7, 32'h11,     1, 7,  1, 0, 0, 0,          0, 0,          0);
    vecs[14] = mk(1, 7, 32'h22,     1, 7,  1, 0, 0, 0,          1, 32'h11,     1);
    vecs[15] = mk(0, 0, 0,          1, 7,  1, 0, 0, 0,          1, 32'h22,     2);
    vecs[16] = mk(0, 0, 0,          1, 0,  1, 0, 0, 0,          0, 0,          2);
    vecs[17] = mk(0, 0, 0,          1, 8,  1, 0, 0, 0,          0, 0,          2);
    vecs[18] = mk(0, 0, 0,          0, 7,  1, 1, 7, 32'h11,     1, 32'h22,     2);
    vecs[19] = mk(0, 0, 0,          0, 7,  1, 1, 7, 32'h22,     1, 32'h22,     1);
    vecs[20] = mk(0, 0, 0,          0, 7,  1, 0, 0, 0,          0, 0,          0);
    // Test 4: x0 result is accepted and discarded.
    vecs[21] = mk(1, 0, 32'hFFFF,   0, 0,  1, 0, 0, 0,          0, 0,          0);
    vecs[22] = mk(0, 0, 0,          0, 0,  1, 0, 0, 0,          0, 0,          0);

    // Reset state, with a push offered that must be ignored.
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    #1 rst = 1'b0;
    drive(1, 5, 32'h1234, 0, 5);
    repeat (2) @(posedge clk);
    #2;
    expect_out("reset", 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();

    // Table vectors: outputs compared on the falling edge of each cycle.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].iv, vecs[i].rd, vecs[i].data, vecs[i].busy, vecs[i].qrs);
      @(negedge clk);
      expect_out($sformatf("v%0d", i), vecs[i].e_rdy, vecs[i].e_wen, vecs[i].e_addr,
                 vecs[i].e_wdata, vecs[i].e_hit, vecs[i].e_qdata, vecs[i].e_cnt);
      tick();
    end

    // Test 5: steady push+pop at count=2 across pointer wrap.
    drive(1, 10, 32'h200, 1, 0);
    tick();
    drive(1, 11, 32'h201, 1, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, 5'(12 + i), 32'h202 + 32'(i), 0, 0);
      @(negedge clk);
      check($sformatf("wrap%0d.count", i),   32'(count),   32'd2);
      check($sformatf("wrap%0d.wr_en", i),   32'(wr_en),   32'd1);
      check($sformatf("wrap%0d.wr_addr", i), 32'(wr_addr), 32'(10 + i));
      check($sformatf("wrap%0d.wr_data", i), wr_data,      32'h200 + 32'(i));
      tick();
    end
    drive(0, 0, 0, 0, 0);
    for (int i = 10; i < 12; i++) begin
      @(negedge clk);
      expect_out($sformatf("wrapdrain%0d", i), 1, 1, 5'(10 + i), 32'h200 + 32'(i),
                 0, 0, 3'(12 - i));
      tick();
    end
    @(negedge clk);
    expect_out("wrapempty", 1, 0, 0, 0, 0, 0, 0);
    tick();

    // Test 6: asynchronous reset while draining three entries.
    for (int i = 1; i <= 3; i++) begin
      drive(1, 5'(i), 32'h300 + 32'(i), 1, 0);
      tick();
    end
    drive(0, 0, 0, 0, 2);
    @(negedge clk);
    expect_out("predrain", 1, 1, 1, 32'h301, 1, 32'h302, 3);
    #1 rst = 1'b0;
    #1;
    expect_out("midrst", 1, 0, 0, 0, 0, 0, 0);
    tick();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      expect_out($sformatf("postrst%0d", i), 1, 0, 0, 0, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Writeback buffer for long-latency results (multiplier/divider, load misses) in the pipelined RISC-V core.
- Accepts (rd, data) results over a valid/ready handshake and buffers them in order.
- Drains them into the register-file write port (address, data, write enable) whenever the main pipeline writeback is not using that port.
- Exposes a pending-destination lookup so hazard/forwarding logic can detect and forward values still in the queue.

Parameters:
- DEPTH, 4, number of buffered entries; power of two, minimum 2.
- XLEN, 32, data width.
- REG_AW, 5, register address width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  producer has a result
- in_ready  output  1  queue can accept; equals !full
- in_rd  input  REG_AW  destination register of incoming result
- in_data  input  XLEN  incoming result value
- port_busy  input  1  main writeback owns the regfile write port this cycle
- wr_en  output  1  regfile write enable
- wr_addr  output  REG_AW  regfile write address
- wr_data  output  XLEN  regfile write data
- q_rs  input  REG_AW  lookup register address
- q_hit  output  1  a pending entry targets q_rs
- q_data  output  XLEN  value of youngest pending entry targeting q_rs
- count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst low, asynchronous): head, tail and count go to 0; all entry valid bits clear. Outputs during reset: wr_en=0, wr_addr=0, wr_data=0, q_hit=0, q_data=0, count=0, in_ready=1.
- Push: occurs at a rising edge with in_valid && in_ready && in_rd!=0. The entry is written at tail, tail increments modulo DEPTH, and the entry valid bit is set.
- in_rd==0 handshake: the handshake completes but nothing is enqueued (x0 writes are discarded).
- Pop: wr_en = !empty && !port_busy (combinational). When wr_en=1:
  - wr_addr/wr_data carry the head entry.
  - On the edge, the head entry is invalidated and head increments modulo DEPTH.
- Idle port outputs: when wr_en=0, wr_addr and wr_data are driven to 0.
- Latency: a result pushed at edge N drives wr_en from edge N onward (visible in cycle N+1) if the port is free. It is written into the regfile at edge N+1.
- port_busy holds the head entry; there is no timeout and no dropping.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full: in_ready=0, and a push is blocked even if a pop occurs in the same cycle (in_ready has no combinational path from port_busy).
- Wrap-around: pointers wrap silently. Full/empty are derived from count, not from pointer equality.
- Lookup (combinational):
  - q_hit=1 iff q_rs!=0 and any valid entry has rd==q_rs.
  - q_data is the data of the youngest such entry (closest to tail); when q_hit=0, q_data=0.
  - The entry being popped this cycle still participates.
  - An entry being pushed this cycle is not visible until the following cycle.
- Ordering: multiple entries may target the same rd. They drain oldest-first, so the final regfile value is the youngest.
- Reset mid-operation: all pending entries are lost; no write is issued after rst falls.

Optional Feature:
- Macro: WBQ_BYPASS_EN.
- With the macro: when the queue is empty, port_busy=0, in_valid=1 and in_rd!=0:
  - The incoming result goes directly to wr_en/wr_addr/wr_data in the same cycle and is not enqueued (zero latency).
  - q_hit does not report bypassed results.
- Without the macro: every result passes through storage, with the minimum latency stated above.

Decomposition:
- Shared package (core_pkg): XLEN, REG_AW, WBQ_DEPTH constants, and the wbq_entry_t typedef {valid, rd[REG_AW-1:0], data[XLEN-1:0]}.
- Sub-module wbq_match: a parameterized priority matcher over DEPTH entries, taking the entry array, head index and q_rs, and returning q_hit and q_data for the youngest match.

Test Plan:
1. Reset, then push rd=5/data=0xDEADBEEF with port_busy=0. Required: wr_en=1, wr_addr=5, wr_data=0xDEADBEEF in the cycle after the push (same cycle with WBQ_BYPASS_EN); count returns to 0.
2. Hold port_busy=1 and push 4 entries (rd=1..4). Required: count=4 and in_ready=0. A 5th push is held. Release port_busy: writes rd=1,2,3,4 in order on consecutive cycles.
3. Push rd=7/0x11 then rd=7/0x22 with port busy, q_rs=7. Required: q_hit=1, q_data=0x22. With q_rs=0 or 8: q_hit=0.
4. Push in_rd=0 with data 0xFFFF. Required: in_ready stays 1, count stays 0, no wr_en.
5. Simultaneous push and pop at count=2 across the pointer wrap (10 cycles). Required: count constant, data order preserved.
6. Assert rst low mid-drain with 3 entries. Required: wr_en=0 immediately (asynchronous), count=0; no stale writes after rst rises.
